load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit for the Memory stage. Takes one
// ld/st request at a time, runs a single-beat word-aligned bus transaction,
// and returns the aligned, sign- or zero-extended load data.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   ld, st, addr, wdata,  request from the Memory stage (funct3 = size/sign)
//   funct3
//   rdata                 last successful load result (held)
//   done, err             one-cycle completion / error pulses
//   stall                 combinational pipeline freeze
//   bus_req, bus_we,      bus request channel, held stable while in REQ
//   bus_addr, bus_wdata,
//   bus_be
//   bus_rdata, bus_ack    bus response
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic        st,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state, stateNext;
  logic [CntW-1:0] reqCnt, reqCntNext;
  logic            latLoad, latLoadNext;
  logic [2:0]      latFunct3, latFunct3Next;
  logic [1:0]      latOffset, latOffsetNext;
  logic [31:0]     rdataNext, busAddrNext, busWdataNext;
  logic [3:0]      busBeNext;
  logic            doneNext, errNext, busReqNext, busWeNext;

  logic            accessLegal, accessAligned, reqValid;
  logic [3:0]      beCalc;
  logic [31:0]     wdataCalc;
  logic [7:0]      laneByte;
  logic [15:0]     laneHalf;
  logic [31:0]     loadData;

  // Request decode: legality, alignment, byte enables and lane-replicated data
  always_comb begin
    accessLegal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: accessLegal = 1'b1;
      3'b100, 3'b101:         accessLegal = ld;  // unsigned forms exist only for loads
      default:                accessLegal = 1'b0;
    endcase
    if (ld && st) accessLegal = 1'b0;

    accessAligned = 1'b0;
    case (funct3[1:0])
      2'b00:   accessAligned = 1'b1;
      2'b01:   accessAligned = ~addr[0];
      2'b10:   accessAligned = (addr[1:0] == 2'b00);
      default: accessAligned = 1'b0;
    endcase

    reqValid = (ld | st) & accessLegal & accessAligned;

    beCalc    = 4'b1111;
    wdataCalc = 32'h0;
    if (st) begin
      case (funct3[1:0])
        2'b00: begin
          beCalc    = 4'b0001 << addr[1:0];
          wdataCalc = {4{wdata[7:0]}};
        end
        2'b01: begin
          beCalc    = addr[1] ? 4'b1100 : 4'b0011;
          wdataCalc = {2{wdata[15:0]}};
        end
        default: begin
          beCalc    = 4'b1111;
          wdataCalc = wdata;
        end
      endcase
    end
  end

  // Load lane selection and extension from the latched offset/size
  always_comb begin
    laneByte = bus_rdata[{latOffset, 3'b000} +: 8];
    laneHalf = latOffset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (latFunct3)
      3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
      3'b100:  loadData = {24'h0, laneByte};
      3'b101:  loadData = {16'h0, laneHalf};
      default: loadData = bus_rdata;
    endcase
  end

  assign stall = ((state == IDLE) && reqValid) || (state == REQ);

  // Next-state and registered-output logic
  always_comb begin
    stateNext     = state;
    reqCntNext    = reqCnt;
    latLoadNext   = latLoad;
    latFunct3Next = latFunct3;
    latOffsetNext = latOffset;
    rdataNext     = rdata;
    doneNext      = 1'b0;
    errNext       = 1'b0;
    busReqNext    = bus_req;
    busWeNext     = bus_we;
    busBeNext     = bus_be;
    busAddrNext   = bus_addr;
    busWdataNext  = bus_wdata;

    case (state)
      IDLE: begin
        if (reqValid) begin
          stateNext     = REQ;
          reqCntNext    = '0;
          latLoadNext   = ld;
          latFunct3Next = funct3;
          latOffsetNext = addr[1:0];
          busReqNext    = 1'b1;
          busWeNext     = st;
          busBeNext     = beCalc;
          busAddrNext   = {addr[31:2], 2'b00};
          busWdataNext  = wdataCalc;
        end else if (ld || st) begin
          errNext = 1'b1;
        end
      end
      REQ: begin
        // An ack in the timeout cycle still completes normally
        if (bus_ack) begin
          stateNext  = RESP;
          doneNext   = 1'b1;
          busReqNext = 1'b0;
          busWeNext  = 1'b0;
          busBeNext  = 4'b0000;
          if (latLoad) rdataNext = loadData;
        end else if (reqCnt == CntLast) begin
          stateNext  = IDLE;
          errNext    = 1'b1;
          busReqNext = 1'b0;
          busWeNext  = 1'b0;
          busBeNext  = 4'b0000;
        end else begin
          reqCntNext = reqCnt + CntW'(1);
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      reqCnt    <= '0;
      latLoad   <= 1'b0;
      latFunct3 <= 3'b000;
      latOffset <= 2'b00;
      rdata     <= 32'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      state     <= stateNext;
      reqCnt    <= reqCntNext;
      latLoad   <= latLoadNext;
      latFunct3 <= latFunct3Next;
      latOffset <= latOffsetNext;
      rdata     <= rdataNext;
      done      <= doneNext;
      err       <= errNext;
      bus_req   <= busReqNext;
      bus_we    <= busWeNext;
      bus_be    <= busBeNext;
      bus_addr  <= busAddrNext;
      bus_wdata <= busWdataNext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed accesses with hand-computed
// results; expected bus requests and responses go into queues that
// independent monitors drain and compare.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld = 1'b0, st = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rdata;
  logic        done, err, stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack;
  logic        respAck = 1'b0, strayAck = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int ackAt = -1;
  int reqCycles = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        isErr;
    logic [31:0] rdata;
  } resp_exp_t;

  bus_exp_t  busQ[$];
  resp_exp_t respQ[$];
  bus_exp_t  held;
  logic      prevReq = 1'b0;

  assign bus_ack = respAck | strayAck;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ld(ld), .st(st), .addr(addr), .wdata(wdata),
    .funct3(funct3), .rdata(rdata), .done(done), .err(err), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: acks in the ackAt-th REQ cycle (0-based), never if negative
  always @(negedge clk) begin
    if (bus_req) begin
      respAck = (reqCycles == ackAt);
      reqCycles++;
    end else begin
      respAck = 1'b0;
      reqCycles = 0;
    end
  end

  // Monitor: bus request contents/stability and done/err responses
  always @(negedge clk) begin
    if (reset) begin
      prevReq = 1'b0;
    end else begin
      if (bus_req && !prevReq) begin
        if (busQ.size() == 0) begin
          check("unexpected_bus_req", 32'(bus_req), 32'd0);
        end else begin
          held = busQ.pop_front();
          check("bus_addr", bus_addr, held.addr);
          check("bus_be", 32'(bus_be), 32'(held.be));
          check("bus_we", 32'(bus_we), 32'(held.we));
          check("bus_wdata", bus_wdata, held.wdata);
        end
      end else if (bus_req && prevReq) begin
        check("bus_stable", {bus_addr[31:2], bus_be, bus_we, 1'b0},
              {held.addr[31:2], held.be, held.we, 1'b0});
      end
      prevReq = bus_req;
      if (done || err) begin
        if (respQ.size() == 0) begin
          check("unexpected_resp", {30'h0, done, err}, 32'd0);
        end else begin
          resp_exp_t e;
          e = respQ.pop_front();
          check("resp_kind", {30'h0, done, err}, {30'h0, ~e.isErr, e.isErr});
          check("resp_rdata", rdata, e.rdata);
        end
      end
    end
  end

  task automatic doAccess(input string name, input bit l, input bit s,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int ack, input bit expBus, input logic [3:0] expBe,
                          input logic [31:0] expWd, input bit expErr,
                          input logic [31:0] expRd, input int expCyc,
                          input int expReqHi);
    int cyc, reqHi;
    bit seen;
    if (expBus) busQ.push_back('{addr: a & 32'hFFFF_FFFC, be: expBe, we: s, wdata: expWd});
    respQ.push_back('{isErr: expErr, rdata: expRd});
    @(posedge clk);
    #1;
    ackAt = ack; bus_rdata = rd;
    ld = l; st = s; funct3 = f3; addr = a; wdata = wd;
    #1;
    check({name, "_stall"}, 32'(stall), 32'(expBus));
    cyc = 1; reqHi = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin ld = 1'b0; st = 1'b0; end
      cyc++;
      if (bus_req) reqHi++;
      if (done || err) begin seen = 1'b1; break; end
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_cycles"}, 32'(cyc), 32'(expCyc));
    check({name, "_req_cycles"}, 32'(reqHi), 32'(expReqHi));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {26'h0, done, err, bus_req, bus_we, stall, 1'b0}, 32'h0);
    check("rst_bus", bus_addr | bus_wdata | 32'(bus_be), 32'h0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    //        name     l  s  f3      addr          wdata         bus_rdata     ack bus be       bus_wdata     err rdata         cyc reqHi
    doAccess("lw",     1, 0, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 0,  1, 4'b1111, 32'h0,        0, 32'hDEADBEEF, 3, 1);
    doAccess("lb",     1, 0, 3'b000, 32'h103,      32'h0,        32'h80FF0000, 0,  1, 4'b1111, 32'h0,        0, 32'hFFFFFF80, 3, 1);
    doAccess("lbu",    1, 0, 3'b100, 32'h103,      32'h0,        32'h80FF0000, 0,  1, 4'b1111, 32'h0,        0, 32'h00000080, 3, 1);
    doAccess("sh",     0, 1, 3'b001, 32'h22,       32'h1234ABCD, 32'h0,        0,  1, 4'b1100, 32'hABCDABCD, 0, 32'h00000080, 3, 1);
    doAccess("lw_mis", 1, 0, 3'b010, 32'h101,      32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        1, 32'h00000080, 2, 0);
    doAccess("lh",     1, 0, 3'b001, 32'h102,      32'h0,        32'h80017FFF, 1,  1, 4'b1111, 32'h0,        0, 32'hFFFF8001, 4, 2);
    doAccess("lhu",    1, 0, 3'b101, 32'h102,      32'h0,        32'h80017FFF, 0,  1, 4'b1111, 32'h0,        0, 32'h00008001, 3, 1);
    doAccess("sb",     0, 1, 3'b000, 32'h101,      32'h000000A5, 32'h0,        0,  1, 4'b0010, 32'hA5A5A5A5, 0, 32'h00008001, 3, 1);
    doAccess("sw",     0, 1, 3'b010, 32'h200,      32'hCAFEF00D, 32'h0,        0,  1, 4'b1111, 32'hCAFEF00D, 0, 32'h00008001, 3, 1);
    doAccess("lh_mis", 1, 0, 3'b001, 32'h101,      32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        1, 32'h00008001, 2, 0);
    doAccess("f3_011", 1, 0, 3'b011, 32'h100,      32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        1, 32'h00008001, 2, 0);
    doAccess("st_100", 0, 1, 3'b100, 32'h100,      32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        1, 32'h00008001, 2, 0);
    doAccess("ld_st",  1, 1, 3'b010, 32'h100,      32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        1, 32'h00008001, 2, 0);
    doAccess("tmo",    1, 0, 3'b010, 32'h300,      32'h0,        32'h55555555, -1, 1, 4'b1111, 32'h0,        1, 32'h00008001, 6, 4);
    doAccess("tmo_ack",1, 0, 3'b010, 32'h300,      32'h0,        32'h11223344, 3,  1, 4'b1111, 32'h0,        0, 32'h11223344, 6, 4);
    doAccess("lb_pos", 1, 0, 3'b000, 32'h100,      32'h0,        32'h0000007F, 0,  1, 4'b1111, 32'h0,        0, 32'h0000007F, 3, 1);

    // Stray ack while idle must produce nothing
    @(posedge clk); #1 strayAck = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("stray_ack", {29'h0, done, err, bus_req}, 32'h0);
    strayAck = 1'b0;

    // Reset in the middle of REQ abandons the access
    busQ.push_back('{addr: 32'h400, be: 4'b1111, we: 1'b0, wdata: 32'h0});
    @(posedge clk); #1;
    ackAt = -1; ld = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1 ld = 1'b0;
    @(posedge clk); #1;
    check("mid_req_busy", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_flags", {26'h0, done, err, bus_req, bus_we, stall, 1'b0}, 32'h0);
    check("mid_rst_bus", bus_addr | bus_wdata | 32'(bus_be), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    doAccess("post_rst", 1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0, 1, 4'b1111, 32'h0, 0, 32'h0BADF00D, 3, 1);

    @(posedge clk); @(posedge clk); #1;
    check("busq_empty", 32'(busQ.size()), 32'd0);
    check("respq_empty", 32'(respQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
